// File: rtl/board_ctrl_pkg.sv
// board_ctrl_pkg: shared switch-field offsets and rate/period helpers for the
// front-panel controller.
//   GO_BIT / CRST_BIT / RATE_BIT / OP_LSB : bit positions inside the sw bus
//   rate_w(n)      : width of a rate index for n selectable rates
//   period(b,k,s)  : tick period in clk cycles at rate k
package board_ctrl_pkg;

  localparam int GO_BIT   = 0;
  localparam int CRST_BIT = 1;
  localparam int RATE_BIT = 2;
  localparam int OP_LSB   = 3;

  function automatic int unsigned rate_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Each rate step divides the period by 2**shift.
  function automatic int unsigned period(int unsigned base, int unsigned k,
                                         int unsigned shift);
    return base >> (k * shift);
  endfunction

endpackage

// File: rtl/board_ctrl_sync_debounce.sv
// sync_debounce: 2-flop synchroniser followed by a stability filter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   din_i        : raw asynchronous input
//   level_o      : debounced level
//   rise_o       : one-cycle pulse in the first cycle level_o reads 1
// The debounced level only follows the synced input after it has differed
// from the current level for DB_CYCLES consecutive cycles.
module sync_debounce #(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic level_o,
  output logic rise_o
);

  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic            s1_q, s2_q;
  logic            db_q, db_d;
  logic            rise_q, rise_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d   = db_q;
    cnt_d  = '0;
    rise_d = 1'b0;
    // Any cycle where the synced input agrees with the level restarts the run.
    if (s2_q != db_q) begin
      if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
        db_d   = s2_q;
        rise_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= din_i;
      s2_q   <= s1_q;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
    end
  end

  assign level_o = db_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/board_ctrl.sv
// board_ctrl: front-panel controller producing the CPU clock-enable.
//   clk, rst          : clock, synchronous active-high reset
//   sw                : {ram_display_addr, display_op, rate, cpu_rst, go} raw
//   step_btn          : raw single-step button
//   tick              : registered one-cycle CPU clock-enable
//   running, cpu_rst  : synchronised go / CPU-reset levels
//   rate_sel          : current rate index
//   display_op, ram_display_addr : synchronised display selectors
module board_ctrl
  import board_ctrl_pkg::*;
#(
  parameter int unsigned BASE_DIV   = 10_000_000,
  parameter int unsigned NUM_RATES  = 4,
  parameter int unsigned RATE_SHIFT = 1,
  parameter int unsigned DB_CYCLES  = 1_000_000,
  parameter int unsigned OP_W       = 3,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [2+OP_W+ADDR_W:0]         sw,
  input  logic                           step_btn,
  output logic                           tick,
  output logic                           running,
  output logic                           cpu_rst,
  output logic [rate_w(NUM_RATES)-1:0]   rate_sel,
  output logic [OP_W-1:0]                display_op,
  output logic [ADDR_W-1:0]              ram_display_addr
);

  localparam int RATE_W = rate_w(NUM_RATES);
  localparam int LVL_W  = 2 + OP_W + ADDR_W;
  localparam int CNT_W  = $clog2(BASE_DIV + 1);

  if (period(BASE_DIV, NUM_RATES - 1, RATE_SHIFT) < 2) begin : g_bad_cfg
    $error("board_ctrl: fastest tick period must be at least 2 clk cycles");
  end

  // Plain level synchronisers: go, cpu reset and the display selectors.
  logic [LVL_W-1:0] lvl_raw, lvl_s1_q, lvl_s2_q;

  assign lvl_raw = {sw[OP_LSB +: OP_W+ADDR_W], sw[CRST_BIT], sw[GO_BIT]};

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_s1_q <= '0;
      lvl_s2_q <= '0;
    end else begin
      lvl_s1_q <= lvl_raw;
      lvl_s2_q <= lvl_s1_q;
    end
  end

  assign running          = lvl_s2_q[0];
  assign cpu_rst          = lvl_s2_q[1];
  assign display_op       = lvl_s2_q[2 +: OP_W];
  assign ram_display_addr = lvl_s2_q[2+OP_W +: ADDR_W];

  // Debounced rate-step switch and single-step button.
  logic rate_rise, step_rise;
  logic unused_rate_lvl, unused_step_lvl;

  sync_debounce #(.DB_CYCLES(DB_CYCLES)) u_rate_db (
    .clk_i   (clk),
    .rst_i   (rst),
    .din_i   (sw[RATE_BIT]),
    .level_o (unused_rate_lvl),
    .rise_o  (rate_rise)
  );

  sync_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
    .clk_i   (clk),
    .rst_i   (rst),
    .din_i   (step_btn),
    .level_o (unused_step_lvl),
    .rise_o  (step_rise)
  );

  // Rate select, divider and tick generation.
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, term;
  logic              tick_q, tick_d;

  assign term = CNT_W'(period(BASE_DIV, 32'(rate_q), RATE_SHIFT) - 1);

  always_comb begin
    rate_d = rate_q;
    cnt_d  = '0;
    tick_d = 1'b0;
    if (rate_rise)
      rate_d = (rate_q == RATE_W'(NUM_RATES - 1)) ? '0 : rate_q + 1'b1;
    if (cpu_rst) begin
      // CPU held in reset: count parked at 0, steps dropped.
      tick_d = 1'b0;
    end else if (running) begin
      // A rate change pre-empts a terminal count so the new period starts clean.
      if (rate_rise) begin
        cnt_d = '0;
      end else if (cnt_q == term) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      tick_d = step_rise;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rate_q <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      rate_q <= rate_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick     = tick_q;
  assign rate_sel = rate_q;

endmodule

// File: tb/tb_board_ctrl.sv
// Bench for board_ctrl with small parameters (periods 16/8/4/2, DB 4).
module tb_board_ctrl;

  localparam int BD = 16, NR = 4, RS = 1, DB = 4, OPW = 3, AW = 10;
  localparam int SWW = 3 + OPW + AW;

  logic            clk = 1'b0;
  logic            rst;
  logic [SWW-1:0]  sw;
  logic            step_btn;
  logic            tick, running, cpu_rst;
  logic [1:0]      rate_sel;
  logic [OPW-1:0]  display_op;
  logic [AW-1:0]   ram_display_addr;

  always #5 clk = ~clk;

  board_ctrl #(
    .BASE_DIV(BD), .NUM_RATES(NR), .RATE_SHIFT(RS),
    .DB_CYCLES(DB), .OP_W(OPW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .step_btn(step_btn),
    .tick(tick), .running(running), .cpu_rst(cpu_rst), .rate_sel(rate_sel),
    .display_op(display_op), .ram_display_addr(ram_display_addr)
  );

  int total = 0, bad = 0, cyc = 0;

  // ---------------- behavioural model ----------------
  // hist[i] = raw {step_btn, sw} sampled i edges ago (zeroed by reset).
  bit [SWW:0]    hist [6];
  bit            m_tick, m_run, m_crst;
  int            m_rate, elapsed, r_new;
  bit [OPW-1:0]  m_op;
  bit [AW-1:0]   m_addr;
  bit            db_rate, db_step, pend_rate, pend_step, t_new;

  function automatic int per(int k);
    return BD >> (k * RS);
  endfunction

  // True when the last DB synced samples all disagree with the current level.
  function automatic bit flips(int b, bit cur);
    for (int i = 2; i <= 5; i++) if (hist[i][b] == cur) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int i = 0; i < 6; i++) hist[i] = '0;
      m_tick = 0; m_run = 0; m_crst = 0; m_rate = 0; m_op = '0; m_addr = '0;
      db_rate = 0; db_step = 0; pend_rate = 0; pend_step = 0; elapsed = 0;
    end else begin
      t_new = 0;
      r_new = pend_rate ? (m_rate + 1) % NR : m_rate;
      if (m_crst) elapsed = 0;
      else if (m_run) begin
        if (pend_rate) elapsed = 0;
        else begin
          elapsed++;
          if (elapsed == per(m_rate)) begin t_new = 1; elapsed = 0; end
        end
      end else begin
        elapsed = 0;
        t_new = pend_step;
      end
      m_tick = t_new;
      m_rate = r_new;
      for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {step_btn, sw};
      m_run  = hist[1][0];
      m_crst = hist[1][1];
      m_op   = hist[1][3 +: OPW];
      m_addr = hist[1][3+OPW +: AW];
      pend_rate = 0;
      pend_step = 0;
      if (flips(2, db_rate))   begin db_rate = ~db_rate; pend_rate = db_rate; end
      if (flips(SWW, db_step)) begin db_step = ~db_step; pend_step = db_step; end
    end
  end

  // ---------------- checking helpers ----------------
  function automatic logic [17:0] dutv();
    return {tick, running, cpu_rst, rate_sel, display_op, ram_display_addr};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic nxt();
    logic [17:0] mv;
    @(posedge clk);
    #2;
    mv = {m_tick, m_run, m_crst, 2'(m_rate), m_op, m_addr};
    total++;
    if (dutv() !== mv) begin
      bad++;
      $display("FAIL model_cmp cycle %0d: dut=%h model=%h", cyc, dutv(), mv);
    end
  endtask

  task automatic wait_tick(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound && at < 0; i++) begin
      nxt();
      if (tick === 1'b1) at = cyc;
    end
    if (at < 0) begin
      total++; bad++;
      $display("FAIL tick_timeout: got no tick expected one within %0d cycles", bound);
    end
  endtask

  // which: 0 running=1, 1 cpu_rst=1, 2 cpu_rst=0, 3 rate_sel changes
  task automatic wait_for(input int which, input int bound, output int at);
    logic [1:0] r0;
    r0 = rate_sel;
    at = -1;
    for (int i = 0; i < bound && at < 0; i++) begin
      nxt();
      case (which)
        0: if (running === 1'b1) at = cyc;
        1: if (cpu_rst === 1'b1) at = cyc;
        2: if (cpu_rst === 1'b0) at = cyc;
        default: if (rate_sel !== r0) at = cyc;
      endcase
    end
    if (at < 0) begin
      total++; bad++;
      $display("FAIL wait_timeout: got no event %0d expected within %0d cycles", which, bound);
    end
  endtask

  task automatic press_rate();
    int at;
    sw[2] = 1'b1;
    wait_for(3, 20, at);
    sw[2] = 1'b0;
    repeat (8) nxt();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t1, t2, rr, pc, n, first, fc;
    int exp_rate [4];
    int exp_sp   [4];
    exp_rate = '{1, 2, 3, 0};
    exp_sp   = '{8, 4, 2, 16};
    rst = 1'b1; sw = '0; step_btn = 1'b0;
    repeat (3) nxt();
    chk("reset_outputs", int'(dutv()), 0);

    // Free-run at rate 0.
    sw[0] = 1'b1; rst = 1'b0;
    wait_for(0, 10, rr);
    wait_tick(40, t1);
    chk("first_tick_latency", t1 - rr, 16);
    wait_tick(40, t2);
    chk("rate0_spacing", t2 - t1, 16);
    chk("rate0_sel", int'(rate_sel), 0);

    // Four rate steps.
    for (int k = 0; k < 4; k++) begin
      press_rate();
      chk("rate_sel_step", int'(rate_sel), exp_rate[k]);
      wait_tick(60, t1);
      wait_tick(60, t2);
      chk("rate_spacing", t2 - t1, exp_sp[k]);
    end

    // Short rate glitch is filtered.
    sw[2] = 1'b1; repeat (2) nxt(); sw[2] = 1'b0;
    repeat (12) nxt();
    chk("glitch2_rate", int'(rate_sel), 0);
    wait_tick(40, t1);
    wait_tick(40, t2);
    chk("glitch2_spacing", t2 - t1, 16);

    // Single step while paused.
    sw[0] = 1'b0;
    repeat (6) nxt();
    pc = cyc; step_btn = 1'b1; n = 0; first = -1;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) step_btn = 1'b0;
      nxt();
      if (tick === 1'b1) begin n++; if (first < 0) first = cyc; end
    end
    chk("step_count", n, 1);
    chk("step_latency", first - pc, 7);

    // CPU reset mid-count, with a step press ignored.
    sw[0] = 1'b1;
    wait_for(0, 10, rr);
    repeat (5) nxt();
    sw[1] = 1'b1;
    nxt();
    chk("crst_lag1", int'(cpu_rst), 0);
    nxt();
    chk("crst_lag2", int'(cpu_rst), 1);
    step_btn = 1'b1; n = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) step_btn = 1'b0;
      nxt();
      if (tick === 1'b1) n++;
    end
    chk("crst_no_tick", n, 0);
    sw[1] = 1'b0;
    wait_for(2, 10, fc);
    wait_tick(40, t1);
    chk("crst_release_period", t1 - fc, 16);

    // Reset mid-count and mid-debounce with rate_sel=2.
    press_rate();
    press_rate();
    chk("pre_rst_rate", int'(rate_sel), 2);
    repeat (3) nxt();
    sw[2] = 1'b1;
    repeat (3) nxt();
    rst = 1'b1; sw[2] = 1'b0;
    nxt();
    chk("rst_mid_all_zero", int'(dutv()), 0);
    rst = 1'b0;
    wait_for(0, 10, rr);
    sw[2] = 1'b1; repeat (3) nxt(); sw[2] = 1'b0;
    wait_tick(40, t1);
    chk("post_rst_latency", t1 - rr, 16);
    chk("post_rst_glitch_rate", int'(rate_sel), 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)   sw[2]    = ~sw[2];
      if ($urandom_range(0, 7) == 0)   step_btn = ~step_btn;
      if ($urandom_range(0, 49) == 0)  sw[0]    = ~sw[0];
      if ($urandom_range(0, 119) == 0) sw[1]    = ~sw[1];
      sw[SWW-1:3] = (OPW+AW)'($urandom);
      rst = ($urandom_range(0, 599) == 0);
      nxt();
    end
    rst = 1'b0;
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
